// File: rtl/ram_dma.sv
// Block copy / block fill initiator for the single-port synchronous RAM.
// Optional running checksum of written bytes enabled with `define RAM_DMA_CHECKSUM_EN.
module ram_dma #(
  parameter int ADDRWIDTH = 12,
  parameter int DATAWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 mode,
  input  logic [ADDRWIDTH-1:0] src,
  input  logic [ADDRWIDTH-1:0] dst,
  input  logic [ADDRWIDTH-1:0] len,
  input  logic [DATAWIDTH-1:0] fill_val,
  output logic                 busy,
  output logic                 done,
  output logic [DATAWIDTH-1:0] checksum,
  output logic [ADDRWIDTH-1:0] mem_addr,
  output logic [DATAWIDTH-1:0] mem_din,
  input  logic [DATAWIDTH-1:0] mem_q,
  output logic                 mem_wr_n,
  output logic                 mem_ce_n
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] FIN  = 2'd3;

  logic [1:0]           state;
  logic [ADDRWIDTH-1:0] src_ptr;
  logic [ADDRWIDTH-1:0] dst_ptr;
  logic [ADDRWIDTH-1:0] count;
  logic                 mode_r;
  logic [DATAWIDTH-1:0] fill_r;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      src_ptr <= '0;
      dst_ptr <= '0;
      count   <= '0;
      mode_r  <= 1'b0;
      fill_r  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            src_ptr <= src;
            dst_ptr <= dst;
            count   <= len;
            mode_r  <= mode;
            fill_r  <= fill_val;
            if (len == '0)  state <= FIN;
            else if (mode)  state <= WR;
            else            state <= RD;
          end
        end
        RD: begin
          src_ptr <= src_ptr + 1'b1;
          state   <= WR;
        end
        WR: begin
          dst_ptr <= dst_ptr + 1'b1;
          count   <= count - 1'b1;
          if (count == ADDRWIDTH'(1)) state <= FIN;
          else if (mode_r)            state <= WR;
          else                        state <= RD;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Everything but copy-mode write data is a pure decode of registered state.
  always_comb begin
    mem_addr = '0;
    mem_din  = '0;
    mem_ce_n = 1'b1;
    mem_wr_n = 1'b1;
    case (state)
      RD: begin
        mem_addr = src_ptr;
        mem_ce_n = 1'b0;
      end
      WR: begin
        mem_addr = dst_ptr;
        mem_ce_n = 1'b0;
        mem_wr_n = 1'b0;
        mem_din  = mode_r ? fill_r : mem_q;
      end
      default: ;
    endcase
  end

  assign busy = (state == RD) || (state == WR);
  assign done = (state == FIN);

`ifdef RAM_DMA_CHECKSUM_EN
  logic [DATAWIDTH-1:0] sum_r;

  always_ff @(posedge clk) begin
    if (!reset_n)                     sum_r <= '0;
    else if (state == IDLE && start)  sum_r <= '0;
    else if (state == WR)             sum_r <= sum_r + mem_din;
  end

  assign checksum = sum_r;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_ram_dma.sv
// Self-checking bench for ram_dma: behavioural RAM plus a reference model of the copy/fill result.
`timescale 1ns/1ps
module tb_ram_dma;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [11:0] src = '0, dst = '0, len = '0;
  logic [7:0]  fill_val = '0;
  logic        busy, done;
  logic [7:0]  checksum;
  logic [11:0] mem_addr;
  logic [7:0]  mem_din, mem_q;
  logic        mem_wr_n, mem_ce_n;

  ram_dma #(.ADDRWIDTH(12), .DATAWIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .src(src), .dst(dst),
    .len(len), .fill_val(fill_val), .busy(busy), .done(done), .checksum(checksum),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_q(mem_q), .mem_wr_n(mem_wr_n),
    .mem_ce_n(mem_ce_n)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with a backdoor write port for preloading.
  logic [7:0]  ram [4096];
  logic [7:0]  q_reg = '0;
  logic        bd_we = 1'b0, rand_init = 1'b1;
  logic [11:0] bd_addr = '0;
  logic [7:0]  bd_data = '0;
  assign mem_q = mem_ce_n ? 8'h00 : q_reg;

  always @(posedge clk) begin
    if (rand_init) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 8'($urandom);
    end else if (bd_we) begin
      ram[bd_addr] <= bd_data;
    end else if (!mem_ce_n) begin
      if (!mem_wr_n) ram[mem_addr] <= mem_din;
      q_reg <= ram[mem_addr];
    end
  end

  // Observation log.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          w_cyc[$];
  logic [11:0] w_addr[$];
  logic [7:0]  w_data[$];
  int          done_cyc[$];
  int          busy_cnt = 0, ce_cnt = 0;

  always @(negedge clk) begin
    if (!mem_ce_n) ce_cnt++;
    if (busy) busy_cnt++;
    if (!mem_ce_n && !mem_wr_n) begin
      w_cyc.push_back(cyc); w_addr.push_back(mem_addr); w_data.push_back(mem_din);
    end
    if (done) done_cyc.push_back(cyc);
  end

  int n_vec = 0, n_err = 0;

  // Reference-model results of the most recent transfer.
  logic [7:0] exp_mem [4096];
  logic [7:0] pre_mem [4096];
  logic [7:0] exp_cks;
  int s_cyc, lat, obs_done, trace_bad, mem_bad;

  task automatic clear_log();
    w_cyc.delete(); w_addr.delete(); w_data.delete(); done_cyc.delete();
    busy_cnt = 0; ce_cnt = 0;
  endtask

  task automatic poke_ram(input logic [11:0] a, input logic [7:0] v);
    @(negedge clk); bd_we = 1'b1; bd_addr = a; bd_data = v;
    @(negedge clk); bd_we = 1'b0;
  endtask

  task automatic scramble_inputs();
    mode = 1'($urandom); src = 12'($urandom); dst = 12'($urandom);
    len = 12'($urandom); fill_val = 8'($urandom);
  endtask

  task automatic run_xfer(input logic m, input logic [11:0] s, input logic [11:0] d,
                          input logic [11:0] l, input logic [7:0] f, input bit poke);
    logic [11:0] sa, da;
    @(negedge clk);
    pre_mem = ram;
    exp_mem = ram;
    exp_cks = 8'h00;
    for (int i = 0; i < int'(l); i++) begin
      sa = 12'(int'(s) + i);
      da = 12'(int'(d) + i);
      exp_mem[da] = m ? f : exp_mem[sa];
      exp_cks = 8'(exp_cks + exp_mem[da]);
    end
    lat = m ? int'(l) : 2 * int'(l);
    clear_log();
    mode = m; src = s; dst = d; len = l; fill_val = f; start = 1'b1;
    @(posedge clk); @(negedge clk); #1;
    s_cyc = cyc;
    start = 1'b0;
    scramble_inputs();
    for (int i = 0; i < lat + 10 && done_cyc.size() == 0; i++) begin
      @(negedge clk); #1;
      start = poke && (i == 1) && (done_cyc.size() == 0);
      if (start) scramble_inputs();
    end
    if (poke && done_cyc.size() != 0) begin
      start = 1'b1; scramble_inputs();
      @(negedge clk); #1;
    end
    start = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    obs_done = (done_cyc.size() != 0) ? done_cyc[0] : -1;
    trace_bad = (w_addr.size() != int'(l)) ? 1 : 0;
    for (int i = 0; i < w_addr.size() && i < int'(l); i++) begin
      da = 12'(int'(d) + i);
      if (w_addr[i] !== da || w_data[i] !== exp_mem[da] ||
          w_cyc[i] != s_cyc + (m ? i : 2 * i + 1)) trace_bad++;
    end
    mem_bad = 0;
    for (int i = 0; i < 4096; i++) if (ram[i] !== exp_mem[i]) mem_bad++;
  endtask

  function automatic logic [7:0] want_cks(input logic [7:0] c);
`ifdef RAM_DMA_CHECKSUM_EN
    return c;
`else
    return 8'h00 & c;
`endif
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    rand_init = 1'b0;
    @(negedge clk); #1;
    n_vec++;
    if ({busy, done, mem_ce_n, mem_wr_n, mem_addr, mem_din, checksum} !==
        {1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 8'h00, 8'h00}) begin
      n_err++;
      $display("FAIL reset_values: busy=%b done=%b ce_n=%b wr_n=%b addr=%h din=%h cks=%h, want 0 0 1 1 000 00 00",
               busy, done, mem_ce_n, mem_wr_n, mem_addr, mem_din, checksum);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_fill();
    run_xfer(1'b1, 12'h000, 12'h100, 12'd4, 8'hA5, 1'b0);
    n_vec++; if (obs_done != s_cyc + 4) begin n_err++; $display("FAIL fill_done_time: got %0d want %0d", obs_done, s_cyc + 4); end
    n_vec++; if (busy_cnt != 4 || done_cyc.size() != 1) begin n_err++; $display("FAIL fill_busy: busy=%0d dones=%0d want 4 1", busy_cnt, done_cyc.size()); end
    n_vec++; if (trace_bad != 0) begin n_err++; $display("FAIL fill_trace: %0d bad writes (n=%0d) want 0", trace_bad, w_addr.size()); end
    n_vec++; if (ram[12'h0FF] !== pre_mem[12'h0FF] || ram[12'h104] !== pre_mem[12'h104] || mem_bad != 0) begin
      n_err++; $display("FAIL fill_neighbours: 0ff=%h/104=%h bad=%0d want %h/%h 0", ram[12'h0FF], ram[12'h104], mem_bad, pre_mem[12'h0FF], pre_mem[12'h104]); end
    n_vec++; if (checksum !== want_cks(8'h94)) begin n_err++; $display("FAIL fill_checksum: got %h want %h", checksum, want_cks(8'h94)); end
  endtask

  task automatic test_copy();
    poke_ram(12'h010, 8'd11); poke_ram(12'h011, 8'd22); poke_ram(12'h012, 8'd33);
    run_xfer(1'b0, 12'h010, 12'h200, 12'd3, 8'h00, 1'b0);
    n_vec++; if ({ram[12'h200], ram[12'h201], ram[12'h202]} !== {8'd11, 8'd22, 8'd33}) begin
      n_err++; $display("FAIL copy_data: got %0d %0d %0d want 11 22 33", ram[12'h200], ram[12'h201], ram[12'h202]); end
    n_vec++; if (obs_done != s_cyc + 6) begin n_err++; $display("FAIL copy_done_time: got %0d want %0d", obs_done, s_cyc + 6); end
    n_vec++; if (busy_cnt != 6 || ce_cnt != 6) begin n_err++; $display("FAIL copy_busy: busy=%0d ce=%0d want 6 6", busy_cnt, ce_cnt); end
    n_vec++; if (trace_bad != 0 || mem_bad != 0) begin n_err++; $display("FAIL copy_trace: trace=%0d mem=%0d want 0 0", trace_bad, mem_bad); end
    n_vec++; if (checksum !== want_cks(8'd66)) begin n_err++; $display("FAIL copy_checksum: got %h want %h", checksum, want_cks(8'd66)); end
  endtask

  task automatic test_wrap();
    run_xfer(1'b1, 12'h000, 12'hFFE, 12'd3, 8'h5A, 1'b0);
    n_vec++; if (w_addr.size() != 3) begin n_err++; $display("FAIL wrap_count: got %0d want 3", w_addr.size()); end
    else if ({w_addr[0], w_addr[1], w_addr[2]} !== {12'hFFE, 12'hFFF, 12'h000}) begin
      n_err++; $display("FAIL wrap_addr: got %h %h %h want ffe fff 000", w_addr[0], w_addr[1], w_addr[2]); end
    n_vec++; if (mem_bad != 0 || trace_bad != 0) begin n_err++; $display("FAIL wrap_mem: mem=%0d trace=%0d want 0 0", mem_bad, trace_bad); end
  endtask

  task automatic test_len_zero();
    run_xfer(1'($urandom), 12'($urandom), 12'($urandom), 12'd0, 8'($urandom), 1'b0);
    n_vec++; if (obs_done != s_cyc || done_cyc.size() != 1) begin n_err++; $display("FAIL len0_done: at %0d (n=%0d) want %0d (1)", obs_done, done_cyc.size(), s_cyc); end
    n_vec++; if (busy_cnt != 0 || ce_cnt != 0 || mem_bad != 0) begin n_err++; $display("FAIL len0_idle: busy=%0d ce=%0d mem=%0d want 0 0 0", busy_cnt, ce_cnt, mem_bad); end
    n_vec++; if (checksum !== 8'h00) begin n_err++; $display("FAIL len0_checksum: got %h want 00", checksum); end
  endtask

  task automatic test_ignored_start();
    run_xfer(1'b0, 12'h600, 12'h700, 12'd5, 8'h00, 1'b1);
    n_vec++; if (done_cyc.size() != 1 || obs_done != s_cyc + 10) begin n_err++; $display("FAIL ign_done: n=%0d at %0d want 1 at %0d", done_cyc.size(), obs_done, s_cyc + 10); end
    n_vec++; if (busy_cnt != 10 || trace_bad != 0 || mem_bad != 0) begin n_err++; $display("FAIL ign_xfer: busy=%0d trace=%0d mem=%0d want 10 0 0", busy_cnt, trace_bad, mem_bad); end
  endtask

  task automatic test_reset_mid();
    int k;
    @(negedge clk);
    pre_mem = ram;
    exp_mem = ram;
    for (int i = 0; i < 2; i++) exp_mem[12'h400 + 12'(i)] = pre_mem[12'h300 + 12'(i)];
    clear_log();
    mode = 1'b0; src = 12'h300; dst = 12'h400; len = 12'd8; start = 1'b1;
    @(negedge clk); #1; start = 1'b0;
    k = 0;
    while (w_addr.size() < 2 && k < 20) begin @(negedge clk); #1; k++; end
    reset_n = 1'b0;
    @(negedge clk); #1;
    n_vec++; if ({busy, mem_ce_n, mem_wr_n, done} !== 4'b0110) begin
      n_err++; $display("FAIL rst_mid_outputs: busy=%b ce_n=%b wr_n=%b done=%b want 0 1 1 0", busy, mem_ce_n, mem_wr_n, done); end
    reset_n = 1'b1;
    repeat (25) @(negedge clk);
    #1;
    mem_bad = 0;
    for (int i = 0; i < 4096; i++) if (ram[i] !== exp_mem[i]) mem_bad++;
    n_vec++; if (done_cyc.size() != 0 || w_addr.size() != 2 || mem_bad != 0) begin
      n_err++; $display("FAIL rst_mid_abandon: dones=%0d writes=%0d mem=%0d want 0 2 0", done_cyc.size(), w_addr.size(), mem_bad); end
    n_vec++; if (checksum !== 8'h00) begin n_err++; $display("FAIL rst_mid_checksum: got %h want 00", checksum); end
  endtask

  task automatic test_random();
    logic m; logic [11:0] l;
    for (int t = 0; t < 10; t++) begin
      m = 1'($urandom);
      l = 12'($urandom_range(1, 24));
      if (t == 0) run_xfer(1'b0, 12'h500, 12'h502, 12'd10, 8'h00, 1'b0);
      else        run_xfer(m, 12'($urandom), 12'($urandom), l, 8'($urandom), 1'b0);
      n_vec++; if (done_cyc.size() != 1 || obs_done != s_cyc + lat) begin
        n_err++; $display("FAIL rand%0d_done: n=%0d at %0d want 1 at %0d", t, done_cyc.size(), obs_done, s_cyc + lat); end
      n_vec++; if (busy_cnt != lat || trace_bad != 0 || mem_bad != 0) begin
        n_err++; $display("FAIL rand%0d_xfer: busy=%0d trace=%0d mem=%0d want %0d 0 0", t, busy_cnt, trace_bad, mem_bad, lat); end
      n_vec++; if (checksum !== want_cks(exp_cks)) begin
        n_err++; $display("FAIL rand%0d_checksum: got %h want %h", t, checksum, want_cks(exp_cks)); end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_copy();
    test_wrap();
    test_len_zero();
    test_ignored_start();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_dma.md
Name: ram_dma

Overview:
- Initiator/master for the single-port synchronous RAM interface used across the design: active-low chip enable, active-low write enable, read data registered one clock after the address, read data gated to zero while chip enable is high.
- Performs block copy (RAM to RAM) or block fill (constant to RAM) on request from a CPU-side register block.
- Lets firmware-visible operations (screen clear, buffer moves) run without per-byte CPU cycles.
- Sits between the control registers and one RAM instance.

Parameters:
- ADDRWIDTH, 12, RAM address width; all pointers and the length counter use this width.
- DATAWIDTH, 8, RAM data width.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  synchronous active-low reset, sampled on the clk rising edge.
- start  in  1  single-cycle request; sampled only while idle.
- mode  in  1  0 = copy, 1 = fill; sampled with start.
- src  in  ADDRWIDTH  copy source start address; sampled with start.
- dst  in  ADDRWIDTH  destination start address; sampled with start.
- len  in  ADDRWIDTH  byte count; 0 = no transfer; sampled with start.
- fill_val  in  DATAWIDTH  fill byte; sampled with start.
- busy  out  1  high while a transfer is in progress.
- done  out  1  one-cycle completion pulse.
- checksum  out  DATAWIDTH  see Optional Feature.
- mem_addr  out  ADDRWIDTH  RAM address.
- mem_din  out  DATAWIDTH  RAM write data.
- mem_q  in  DATAWIDTH  RAM read data; valid the cycle after a read address, while mem_ce_n = 0.
- mem_wr_n  out  1  RAM write enable, active low.
- mem_ce_n  out  1  RAM chip enable, active low.

Behaviour:
- Reset values:
  - busy = 0, done = 0, checksum = 0.
  - mem_ce_n = 1, mem_wr_n = 1.
  - mem_addr = 0, mem_din = 0.
  - State = IDLE; internal pointers and counter cleared.
- Reset mid-transfer:
  - Abandons the transfer at the next edge and gives the reset values above.
  - No done pulse.
  - A write already performed stays in RAM.
- States: IDLE, RD, WR, FIN.
- IDLE:
  - Outputs mem_ce_n = 1, mem_wr_n = 1.
  - start = 1 at edge S latches src, dst, len, mode and fill_val.
  - If len = 0, go to FIN.
  - Else if mode = 0, go to RD; else go to WR.
- RD (copy only):
  - mem_addr = src_ptr, mem_ce_n = 0, mem_wr_n = 1.
  - Next state WR; src_ptr increments.
- WR:
  - mem_addr = dst_ptr, mem_ce_n = 0, mem_wr_n = 0.
  - mem_din = mem_q in copy mode (combinational; this is the data from the preceding RD). mem_din = fill_val in fill mode.
  - dst_ptr increments and the count decrements.
  - If the count reaches 0, go to FIN.
  - Otherwise go to RD (copy) or stay in WR (fill).
- FIN:
  - done = 1 for exactly one cycle; mem_ce_n = 1, mem_wr_n = 1.
  - Next state IDLE. A new start is accepted from the cycle after FIN.
- busy is 1 in RD and WR only.
  - With len = 0, busy stays 0 and done pulses at cycle S+1.
- Throughput and latency:
  - Copy: 2 cycles per byte. Fill: 1 cycle per byte.
  - The first memory cycle is S+1.
  - done occurs at S+1+2*len (copy) or S+1+len (fill).
- All outputs are decoded from registers, except mem_din in copy mode.
- Pointers wrap modulo 2^ADDRWIDTH (0xFFF + 1 = 0x000 at the default width).
- Copy always runs in ascending address order.
  - Overlap with dst > src replicates the source pattern. This is intended and documented for software.
- start while busy or in FIN is ignored; it is not queued.
- Input changes after S have no effect on the running transfer.

Optional Feature:
- Macro: RAM_DMA_CHECKSUM_EN.
- Defined:
  - checksum is cleared to 0 at start acceptance.
  - Each WR cycle adds the written byte modulo 2^DATAWIDTH.
  - The value holds from FIN until the next accepted start.
- Undefined:
  - checksum is constantly 0.
  - No adder or register is synthesized.

Test Plan:
1. Fill: start, mode = 1, dst = 0x100, len = 4, fill_val = 0xA5.
   - Required: 4 consecutive write cycles at 0x100..0x103, done 5 cycles after S.
   - Required: RAM 0x0FF and 0x104 are unchanged.
   - With the macro: checksum = 0x94.
2. Copy: preload 0x010..0x012 = 11, 22, 33; start, mode = 0, src = 0x010, dst = 0x200, len = 3.
   - Required: alternating RD/WR cycles; 0x200..0x202 = 11, 22, 33; done at S+7; busy high for 6 cycles.
3. Wrap: fill with dst = 0xFFE, len = 3, fill_val = 0x5A.
   - Required: writes to 0xFFE, 0xFFF, then 0x000.
4. len = 0: start with len = 0.
   - Required: done at S+1, busy never asserts, mem_ce_n stays 1 throughout.
5. Ignored start: pulse start again mid-copy.
   - Required: the running transfer is unaffected and no second transfer occurs.
6. Reset mid-transfer: assert reset_n = 0 during a copy with len = 8, after 2 bytes.
   - Required: next cycle busy = 0, mem_ce_n = 1, mem_wr_n = 1; no done pulse; only 2 destination bytes written.
